ifetch_unit: RTL and testbench

- Instruction-fetch front end, the consumer side of the PC register.
- Reads `pc` and issues it as a request to instruction memory over a valid/ready channel.
- Pairs each in-order response with its fetch address and buffers the pair in a small queue for decode.
- Generates the `pcWrite` advance/stall strobe the PC register consumes, and discards wrong-path responses after a redirect.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/ifetch_unit.sv | 126 ++++++++++++
 tb/tb_ifetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package rv_fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  // One decoded-side queue entry: fetch address paired with its instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with async active-low reset and synchronous clear.
// Head entry is presented directly from registered storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clr,
  input  logic                             i_push,
  input  logic [WIDTH-1:0]                 i_data,
  input  logic                             i_pop,
  output logic [WIDTH-1:0]                 o_data,
  output logic                             o_empty,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop qualification; a full FIFO may still push when it also pops.
  always_comb begin
    w_full    = (r_count == CNT_W'(DEPTH));
    w_do_pop  = i_pop & (r_count != '0);
    w_do_push = i_push & (~w_full | w_do_pop);
  end

  // Storage write; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update; clear wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Head and status outputs.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_empty = (r_count == '0);
    o_count = r_count;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: issues pc to imem, pairs in-order responses with
// their fetch address, buffers them for decode, and drives the PC advance strobe.
module ifetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pcWrite,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FQ_DEPTH);

  logic [CNT_W-1:0] r_in_flight;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_in_flight_d;
  logic [CNT_W-1:0] w_drop_cnt_d;

  logic             w_credit_ok;
  logic             w_accept;
  logic             w_rsp;
  logic             w_rsp_keep;
  logic             w_pop;

  logic [XLEN-1:0]  w_tag_head;
  logic             w_tag_empty;
  logic [CNT_W-1:0] w_unused_tag_count;

  fetch_entry_t     w_q_in;
  fetch_entry_t     w_q_head;
  logic             w_q_empty;
  logic [CNT_W-1:0] w_q_count;

  // Request side: credit counts slots already promised to in-flight fetches.
  always_comb begin
    w_credit_ok    = ({1'b0, r_in_flight} + {1'b0, w_q_count}) < DEPTH_W;
    imem_req_addr  = pc;
    imem_req_valid = reset_n & ~flush & w_credit_ok;
    w_accept       = imem_req_valid & imem_req_ready;
    pcWrite        = reset_n & (flush | w_accept);
  end

  // Response side: stray responses with nothing in flight are ignored; wrong-path
  // responses (drop_cnt > 0) and responses in a flush cycle are discarded.
  always_comb begin
    w_rsp      = imem_rsp_valid & (r_in_flight != '0);
    w_rsp_keep = w_rsp & ~flush & (r_drop_cnt == '0) & ~w_tag_empty;
    w_q_in     = '{pc: w_tag_head, instr: imem_rsp_data};
    w_pop      = id_valid & id_ready;
  end

  // Decode side outputs straight from the queue head.
  always_comb begin
    id_valid = ~w_q_empty & ~flush;
    id_instr = w_q_head.instr;
    id_pc    = w_q_head.pc;
  end

  // Counter next-state; on flush everything still outstanding becomes droppable.
  always_comb begin
    w_in_flight_d = r_in_flight;
    w_drop_cnt_d  = r_drop_cnt;
    if (w_accept) w_in_flight_d = w_in_flight_d + CNT_W'(1);
    if (w_rsp)    w_in_flight_d = w_in_flight_d - CNT_W'(1);
    if (flush) begin
      w_drop_cnt_d = w_in_flight_d;
    end else if (w_rsp && (r_drop_cnt != '0)) begin
      w_drop_cnt_d = r_drop_cnt - CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_flight <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_in_flight <= w_in_flight_d;
      r_drop_cnt  <= w_drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (flush),
    .i_push  (w_accept),
    .i_data  (pc),
    .i_pop   (w_rsp_keep),
    .o_data  (w_tag_head),
    .o_empty (w_tag_empty),
    .o_count (w_unused_tag_count)
  );

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_q (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (flush),
    .i_push  (w_rsp_keep),
    .i_data  (w_q_in),
    .i_pop   (w_pop),
    .o_data  (w_q_head),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: behavioural PC register and in-order memory,
// with a scoreboard of expected {pc, instr} pairs checked at each decode pop.
module tb_ifetch_unit;

  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5A5A5;
  localparam logic [31:0] SENTINEL = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        flush;
  logic        pcWrite;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          n_pops   = 0;
  logic        last_pw  = 1'b0;
  logic        watch    = 1'b0;
  logic [31:0] watched_pc = 32'h0;
  logic [31:0] pc_target  = 32'h0;
  logic [31:0] start_pc;
  int          p0;

  logic [31:0] mem_addr_q [$];
  int          mem_due_q  [$];
  logic [63:0] exp_q      [$];

  ifetch_unit #(
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .flush          (flush),
    .pcWrite        (pcWrite),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then update PC model and memory after posedge.
  task automatic tick();
    logic        acc;
    logic        fl;
    logic [63:0] e;
    @(negedge clk);
    if (id_valid && id_ready) begin
      check("id_exp_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("id_pc", {32'd0, id_pc}, {32'd0, e[63:32]});
        check("id_instr", {32'd0, id_instr}, {32'd0, e[31:0]});
        n_pops++;
        if (watch) begin
          watched_pc = id_pc;
          watch      = 1'b0;
        end
      end
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      check("req_addr", {32'd0, imem_req_addr}, {32'd0, pc});
      mem_addr_q.push_back(pc);
      mem_due_q.push_back(cyc + mem_lat);
      exp_q.push_back({pc, pc ^ XOR_KEY});
    end
    last_pw = pcWrite;
    fl      = flush;
    if (fl || !reset_n) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (last_pw) pc = fl ? pc_target : pc + 32'd4;
    if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr_q[0] ^ XOR_KEY;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  // Stop issuing and let everything outstanding come back and drain to decode.
  task automatic drain();
    imem_req_ready = 1'b0;
    id_ready       = 1'b1;
    flush          = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_addr_q.size() == 0 && exp_q.size() == 0 && !imem_rsp_valid) break;
      tick();
    end
    check("drain_done", 64'(mem_addr_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n        = 1'b1;
    pc             = 32'h0;
    flush          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b0;
    #1 reset_n = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_pcwrite", {63'd0, pcWrite}, 64'd0);
    check("rst_id_valid", {63'd0, id_valid}, 64'd0);
    check("rst_id_instr", {32'd0, id_instr}, 64'd0);
    check("rst_id_pc", {32'd0, id_pc}, 64'd0);

    // Release: fetch starts at 0 right away.
    @(posedge clk);
    #1;
    reset_n        = 1'b1;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    mem_lat        = 1;
    #2;
    check("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("rel_req_addr", {32'd0, imem_req_addr}, 64'd0);
    check("rel_pcwrite", {63'd0, pcWrite}, 64'd1);

    // Streaming at one instruction per cycle.
    p0 = n_pops;
    repeat (8) begin
      tick();
      check("stream_pcwrite", {63'd0, last_pw}, 64'd1);
    end
    check("stream_pops", 64'(n_pops - p0), 64'd6);

    // Decode backpressure: exactly FQ_DEPTH fetches, then stall.
    drain();
    start_pc       = pc;
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    mem_lat        = 1;
    repeat (6) tick();
    #2;
    check("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("bp_pcwrite", {63'd0, pcWrite}, 64'd0);
    check("bp_pc_hold", {32'd0, pc}, {32'd0, start_pc + 32'd16});
    check("bp_queued", 64'(exp_q.size()), 64'(FQ_DEPTH));
    id_ready = 1'b1;
    #1;
    check("bp_head_pc", {32'd0, id_pc}, {32'd0, start_pc});
    check("bp_no_req_yet", {63'd0, imem_req_valid}, 64'd0);
    tick();
    #2;
    check("bp_resume_valid", {63'd0, imem_req_valid}, 64'd1);
    check("bp_resume_addr", {32'd0, imem_req_addr}, {32'd0, start_pc + 32'd16});
    repeat (6) tick();

    // Flush with two fetches in flight, 3-cycle memory.
    drain();
    pc_target      = 32'h100;
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    #2;
    check("fl_pcwrite", {63'd0, pcWrite}, 64'd1);
    check("fl_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("fl_id_valid", {63'd0, id_valid}, 64'd0);
    tick();
    flush      = 1'b0;
    watched_pc = SENTINEL;
    watch      = 1'b1;
    repeat (10) tick();
    check("fl_first_pc", {32'd0, watched_pc}, 64'h100);

    // Flush coinciding with a response, two in flight.
    drain();
    pc_target      = 32'h200;
    mem_lat        = 2;
    imem_req_ready = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    #2;
    check("flr_pcwrite", {63'd0, pcWrite}, 64'd1);
    check("flr_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick();
    flush      = 1'b0;
    watched_pc = SENTINEL;
    watch      = 1'b1;
    repeat (10) tick();
    check("flr_first_pc", {32'd0, watched_pc}, 64'h200);

    // Async reset with three in flight and one queued.
    drain();
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    repeat (4) tick();
    #2;
    check("ar_pre_id_valid", {63'd0, id_valid}, 64'd1);
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    pc             = 32'h0;
    #1;
    check("ar_id_valid", {63'd0, id_valid}, 64'd0);
    check("ar_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("ar_pcwrite", {63'd0, pcWrite}, 64'd0);
    tick();
    reset_n  = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_addr_q.size() == 0 && !imem_rsp_valid) break;
      tick();
    end
    check("ar_stale_drained", 64'(mem_addr_q.size()), 64'd0);
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    watched_pc     = SENTINEL;
    watch          = 1'b1;
    #2;
    check("ar_restart_valid", {63'd0, imem_req_valid}, 64'd1);
    check("ar_restart_addr", {32'd0, imem_req_addr}, 64'd0);
    repeat (6) tick();
    check("ar_first_pc", {32'd0, watched_pc}, 64'd0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
